// File: rtl/ser_rx_crc_check.sv
// Bit-serial receiver: rebuilds a 32-bit payload and an optional 16-bit CRC field,
// recomputes CRC-16 over the payload and flags mismatches, aborted or timed-out frames.
module ser_rx_crc_check #(
  parameter logic [15:0] POLY    = 16'h1021,
  parameter logic [15:0] INIT    = 16'h0000,
  parameter int          TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mode,
  input  logic        frame_start,
  input  logic        serial_in,
  input  logic        bit_valid,
  output logic [31:0] rx_payload,
  output logic [15:0] rx_crc,
  output logic        rx_valid,
  output logic        crc_err,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CRC, DONE} state_t;

  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          mode_q;
  logic          pending_q;
  logic          pending_mode_q;
  logic [31:0]   pay_sr;
  logic [15:0]   crc_sr;
  logic [15:0]   crc_q;
  logic [5:0]    bit_cnt;
  logic [TW-1:0] to_cnt;

  logic start, start_mode, take_bit, finish, abort, tout;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
  endfunction

  assign busy = (state_q == PAYLOAD) || (state_q == CRC);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    start_mode = mode;
    take_bit   = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    tout       = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A start pulse seen during DONE is replayed here with the mode it carried.
        if (frame_start || pending_q) begin
          start      = 1'b1;
          start_mode = frame_start ? mode : pending_mode_q;
          state_d    = PAYLOAD;
        end
      end
      PAYLOAD, CRC: begin
        if (frame_start) begin
          abort   = 1'b1;
          start   = 1'b1;
          state_d = PAYLOAD;
        end else if (bit_valid) begin
          take_bit = 1'b1;
          if (state_q == PAYLOAD && bit_cnt == 6'd31) begin
            state_d = mode_q ? CRC : DONE;
            finish  = !mode_q;
          end else if (state_q == CRC && bit_cnt == 6'd47) begin
            state_d = DONE;
            finish  = 1'b1;
          end
        end else if (to_cnt == TO_LAST) begin
          tout    = 1'b1;
          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q         <= 1'b0;
      pending_q      <= 1'b0;
      pending_mode_q <= 1'b0;
      pay_sr         <= '0;
      crc_sr         <= '0;
      crc_q          <= INIT;
      bit_cnt        <= '0;
      to_cnt         <= '0;
      rx_payload     <= '0;
      rx_crc         <= '0;
      rx_valid       <= 1'b0;
      crc_err        <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= abort || tout;

      // A data bit coinciding with a start pulse in DONE is not buffered;
      // the replayed frame takes its first bit from the IDLE cycle.
      if (state_q == DONE && frame_start) begin
        pending_q      <= 1'b1;
        pending_mode_q <= mode;
      end else if (start) begin
        pending_q <= 1'b0;
      end

      if (start) begin
        mode_q <= start_mode;
        to_cnt <= '0;
        crc_sr <= '0;
        if (bit_valid) begin
          pay_sr  <= {31'b0, serial_in};
          crc_q   <= crc_step(INIT, serial_in);
          bit_cnt <= 6'd1;
        end else begin
          pay_sr  <= '0;
          crc_q   <= INIT;
          bit_cnt <= '0;
        end
      end else if (take_bit) begin
        to_cnt  <= '0;
        bit_cnt <= bit_cnt + 6'd1;
        if (state_q == PAYLOAD) begin
          pay_sr <= {pay_sr[30:0], serial_in};
          crc_q  <= crc_step(crc_q, serial_in);
        end else begin
          crc_sr <= {crc_sr[14:0], serial_in};
        end
        if (finish) begin
          rx_valid <= 1'b1;
          if (state_q == PAYLOAD) begin
            rx_payload <= {pay_sr[30:0], serial_in};
            rx_crc     <= '0;
            crc_err    <= 1'b0;
          end else begin
            rx_payload <= pay_sr;
            rx_crc     <= {crc_sr[14:0], serial_in};
            crc_err    <= ({crc_sr[14:0], serial_in} != crc_q);
          end
        end
      end else if (busy) begin
        to_cnt <= tout ? '0 : to_cnt + 1'b1;
      end
    end
  end

endmodule
